// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity beats to the router.
// Optional ROUTER_TX_ERR_INJECT_EN lets corrupt_par flip bit 0 of the parity beat.
module router_pkt_tx #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        dest_addr,
    input  logic [DATA_W-3:0] pay_len,
    input  logic [DATA_W-1:0] pay_data,
    input  logic              pay_valid,
    output logic              pay_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              tx_active,
    output logic              done,
    output logic              req_err,
    input  logic              corrupt_par
);

    localparam int LEN_W = DATA_W - 2;
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [DATA_W-1:0] par_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] buf_q [MAX_LEN];

    logic              req_ok;
    logic              accept;
    logic              reject;
    logic              wr_en;
    logic              xfer;
    logic              last;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] par_beat;

`ifdef ROUTER_TX_ERR_INJECT_EN
    logic inj_q;
    assign par_beat = par_q ^ {{(DATA_W-1){1'b0}}, inj_q};
`else
    logic unused_corrupt;
    assign unused_corrupt = corrupt_par;
    assign par_beat = par_q;
`endif

    assign header    = {len_q, addr_q};
    assign req_ok    = (dest_addr != 2'd3) && (pay_len != '0) && (pay_len <= MAX_L);
    assign last      = (idx_q == len_q - 1'b1);
    assign tx_active = (state_q != IDLE);
    assign done      = done_q;
    assign req_err   = err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pay_ready = 1'b0;
        data_out  = '0;
        pkt_valid = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        wr_en     = 1'b0;
        xfer      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        accept  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LOAD: begin
                pay_ready = 1'b1;
                wr_en     = pay_valid;
                if (pay_valid && last) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                data_out  = header;
                pkt_valid = 1'b1;
                xfer      = !busy;
                if (!busy) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                data_out  = buf_q[idx_q[AW-1:0]];
                pkt_valid = 1'b1;
                xfer      = !busy;
                if (!busy && last) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                data_out = par_beat;
                xfer     = !busy;
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            par_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
            inj_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= reject;
            if (accept) begin
                addr_q <= dest_addr;
                len_q  <= pay_len;
                idx_q  <= '0;
                par_q  <= '0;
`ifdef ROUTER_TX_ERR_INJECT_EN
                inj_q  <= corrupt_par;
`endif
            end
            if (wr_en) begin
                par_q <= par_q ^ pay_data;
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
            if (xfer) begin
                if (state_q == HEADER) begin
                    par_q <= par_q ^ header;
                    idx_q <= '0;
                end else if (state_q == PAYLOAD) begin
                    idx_q <= idx_q + 1'b1;
                end else if (state_q == PARITY) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Payload storage is deliberately not reset; stale words are never read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[idx_q[AW-1:0]] <= pay_data;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: beat sequences, stall, rejects, injection, reset.
module tb_router_pkt_tx;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       req_err;
    logic       corrupt_par;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int hold_cnt = 0;

    logic [8:0] beats [$];
    logic [8:0] exp_q [$];
    logic [7:0] pay_q [$];
    logic [7:0] exp_par;

    router_pkt_tx #(.DATA_W(8), .MAX_LEN(16)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dest_addr   (dest_addr),
        .pay_len     (pay_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .busy        (busy),
        .data_out    (data_out),
        .pkt_valid   (pkt_valid),
        .tx_active   (tx_active),
        .done        (done),
        .req_err     (req_err),
        .corrupt_par (corrupt_par)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetn && tx_active && !pay_ready && !busy) beats.push_back({pkt_valid, data_out});
        if (done) done_cnt++;
        if (req_err) err_cnt++;
        if (pkt_valid && data_out == 8'h22) hold_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [1:0] a, input logic [5:0] l, input logic c);
        start       = 1'b1;
        dest_addr   = a;
        pay_len     = l;
        corrupt_par = c;
        @(posedge clock); #1;
        start       = 1'b0;
        corrupt_par = 1'b0;
        check("load_entered", {30'd0, tx_active, pay_ready}, 32'd3);
        foreach (pay_q[i]) begin
            pay_data  = pay_q[i];
            pay_valid = 1'b1;
            @(posedge clock); #1;
        end
        pay_valid = 1'b0;
        pay_data  = 8'h00;
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic c, input int stall);
        int n;
        beats.delete();
        done_cnt = 0;
        hold_cnt = 0;
        start_load(a, l, c);
        if (stall > 0) begin
            @(posedge clock); #1;
            @(posedge clock); #1;
            busy = 1'b1;
            repeat (stall) @(posedge clock);
            #1 busy = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        #1;
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_count"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < beats.size()) check(tag, {23'd0, beats[i]}, {23'd0, exp_q[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; dest_addr = 2'd0; pay_len = 6'd0;
        pay_data = 8'h00; pay_valid = 1'b0; busy = 1'b0; corrupt_par = 1'b0;
        #2;
        check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_tx_active", {31'd0, tx_active}, 32'd0);
        check("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_req_err", {31'd0, req_err}, 32'd0);
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;

        pay_q = '{8'h11, 8'h22, 8'h33};
        run_pkt(2'd1, 6'd3, 1'b0, 0);
        exp_q = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D};
        check_beats("basic_beat");
        check("basic_done_cnt", done_cnt, 1);

        run_pkt(2'd1, 6'd3, 1'b0, 3);
        check_beats("stall_beat");
        check("stall_hold", hold_cnt, 4);
        check("stall_done_cnt", done_cnt, 1);

        for (int k = 0; k < 3; k++) begin
            err_cnt   = 0;
            start     = 1'b1;
            dest_addr = (k == 0) ? 2'd3 : 2'd1;
            pay_len   = (k == 0) ? 6'd3 : ((k == 1) ? 6'd0 : 6'd17);
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            check("err_pulse", {31'd0, req_err}, 32'd1);
            check("err_tx_active", {31'd0, tx_active}, 32'd0);
            check("err_pkt_valid", {31'd0, pkt_valid}, 32'd0);
            @(negedge clock);
            check("err_clear", {31'd0, req_err}, 32'd0);
            check("err_cnt", err_cnt, 1);
        end

`ifdef ROUTER_TX_ERR_INJECT_EN
        exp_par = 8'h0C;
`else
        exp_par = 8'h0D;
`endif
        run_pkt(2'd1, 6'd3, 1'b1, 0);
        exp_q = '{9'h10D, 9'h111, 9'h122, 9'h133, {1'b0, exp_par}};
        check_beats("inject_beat");

        beats.delete();
        start_load(2'd1, 6'd3, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_rst_beat", {23'd0, pkt_valid, data_out}, 32'h122);
        resetn = 1'b0;
        #1;
        check("mid_rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check("mid_rst_tx_active", {31'd0, tx_active}, 32'd0);
        check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
        @(posedge clock); #3;
        resetn = 1'b1;

        pay_q = '{8'hA5};
        run_pkt(2'd2, 6'd1, 1'b0, 0);
        exp_q = '{9'h106, 9'h1A5, 9'h0A3};
        check_beats("post_rst_beat");
        check("post_rst_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001: Parameter DATA_W, default 8, width of packet beats; header = {length[DATA_W-1:2], addr[1:0]}.
REQ-002: Parameter MAX_LEN, default 16, payload buffer depth in words (1..2^(DATA_W-2)-1).
REQ-003: Clock is clock, reset is resetn; single clock domain; reset asynchronous, active-low.
REQ-004: clock  in  1  rising-edge clock for all state.
REQ-005: resetn  in  1  asynchronous active-low reset.
REQ-006: start  in  1  request to send one packet, sampled only in IDLE.
REQ-007: dest_addr  in  2  destination port 0..2; 3 is illegal.
REQ-008: pay_len  in  DATA_W-2  payload word count, legal 1..MAX_LEN.
REQ-009: pay_data  in  DATA_W  payload word.
REQ-010: pay_valid  in  1  payload word present.
REQ-011: pay_ready  out  1  module accepts payload word this cycle.
REQ-012: busy  in  1  router back-pressure; high stalls the presented beat.
REQ-013: data_out  out  DATA_W  packet beat to router data input.
REQ-014: pkt_valid  out  1  high on header and payload beats, low on parity beat and idle.
REQ-015: tx_active  out  1  high in any state other than IDLE.
REQ-016: done  out  1  one-cycle pulse when the parity beat is consumed.
REQ-017: req_err  out  1  one-cycle pulse when start is rejected.
REQ-018: corrupt_par  in  1  error-injection request, sampled with start (see Configuration).

Function
REQ-019: FSM states IDLE, LOAD, HEADER, PAYLOAD, PARITY; register-based, one state per packet phase.
REQ-020: IDLE: start=1 with dest_addr<=2 and 1<=pay_len<=MAX_LEN latches addr/len, clears parity, clears word index, goes to LOAD next edge.
REQ-021: IDLE: start=1 with illegal addr or len pulses req_err the following cycle; state stays IDLE.
REQ-022: start outside IDLE is ignored; no req_err.
REQ-023: LOAD: pay_ready=1; each edge with pay_valid=1 writes pay_data to buffer[idx], XORs it into parity, increments idx.
REQ-024: LOAD: on acceptance of word pay_len, go to HEADER; pay_ready=0 in all other states.
REQ-025: A beat transfers on a rising edge where it is presented and busy=0; with busy=1 data_out and pkt_valid hold unchanged.
REQ-026: HEADER: data_out={len,addr}, pkt_valid=1; header XORed into parity; on transfer go to PAYLOAD with idx=0.
REQ-027: PAYLOAD: data_out=buffer[idx], pkt_valid=1; on transfer idx increments; after word pay_len go to PARITY.
REQ-028: PARITY: data_out=XOR of header and all payload words, pkt_valid=0; on transfer pulse done, go to IDLE.
REQ-029: pkt_valid stays high contiguously from header through last payload word; no idle gaps inside a packet.
REQ-030: Back-to-back: start may be accepted in the cycle after done; earliest next header beat follows its LOAD phase.
REQ-031: data_out in IDLE and LOAD is 0.

Reset
REQ-032: resetn low forces state IDLE, pkt_valid=0, data_out=0, pay_ready=0, tx_active=0, done=0, req_err=0, idx=0, parity=0, immediately and independent of clock.
REQ-033: Reset mid-packet abandons the packet; buffer contents are not cleared and are don't-care.
REQ-034: First start is honoured on the first rising edge after resetn deasserts.

Configuration
REQ-035: Macro ROUTER_TX_ERR_INJECT_EN defined: corrupt_par sampled with an accepted start inverts bit 0 of that packet's parity beat.
REQ-036: Macro ROUTER_TX_ERR_INJECT_EN undefined: corrupt_par is ignored; parity is always correct.

Verification
REQ-037: DATA_W=8, addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> beats 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, done pulses once.
REQ-038: Same packet, busy=1 for 3 cycles while 0x22 presented -> 0x22 held 4 cycles, sequence and parity unchanged.
REQ-039: start with dest_addr=3, or pay_len=0, or pay_len=17 -> req_err one pulse, tx_active stays 0, pkt_valid stays 0.
REQ-040: Macro defined, corrupt_par=1 on the REQ-037 packet -> parity beat 0x0C; macro undefined -> 0x0D.
REQ-041: resetn low during second payload beat -> pkt_valid=0 and tx_active=0 same cycle; new packet addr=2,len=1,payload 0xA5 -> beats 0x06,0xA5,0xA3.
